// File: rtl/shifter_pkg.sv
// Shared definitions for the RV32I shifter family (left logical, right
// logical, right arithmetic). Holds the data width, the shift-amount
// width and the common word type so every shifter agrees on them.
package shifter_pkg;

    // Datapath width. Only 32 is supported, and the barrel structure
    // needs it to be a power of two.
    localparam int unsigned XLEN    = 32;

    // Width of the effective shift amount: log2(XLEN).
    localparam int unsigned SHAMT_W = 5;

    // One datapath word.
    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/lsl_stage.sv
// One stage of the logarithmic left barrel shifter. When en is set, the
// stage shifts d left by the fixed distance DIST and zero-fills the
// vacated low bits. When en is clear, d passes through unchanged. Bits
// shifted past the MSB are discarded, so this is not a rotate.
module lsl_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DIST = 1
)
(
    input  logic [XLEN-1:0] d,
    input  logic            en,
    output logic [XLEN-1:0] q
);

    // Fixed-distance shift with zero fill. The upper DIST bits of d fall
    // off the top of the word.
    logic [XLEN-1:0] w_shifted;

    assign w_shifted = {d[XLEN-1-DIST:0], {DIST{1'b0}}};
    assign q         = en ? w_shifted : d;

endmodule

// File: rtl/left_l_shifter.sv
// Logical left shifter for the RV32I ALU (SLL/SLLI): S = A << B[4:0].
// It is a five-stage logarithmic barrel. Stage k shifts by 2^k when
// shift-amount bit k is set. B[31:5] are ignored, so B=32 means no shift.
//
// Build option LEFT_L_SHIFTER_REG_EN:
//   undefined (default) - purely combinational. clk and reset are unused,
//                         and S has no reset state.
//   defined             - S is registered after the last stage. Latency is
//                         1 cycle, and a new operand is accepted every
//                         cycle. reset clears S asynchronously.
module left_l_shifter
    import shifter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] S
);

    // Effective shift amount. The upper bits of B do not affect SLL.
    logic [SHAMT_W-1:0] w_shamt;

    // w_stage[0] is the operand and w_stage[k+1] is the output of stage k.
    word_t              w_stage [0:SHAMT_W];

    assign w_shamt    = B[SHAMT_W-1:0];
    assign w_stage[0] = A;

    // Barrel: stage k conditionally shifts by 2^k (distances 1, 2, 4, 8, 16).
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        lsl_stage #(
            .DIST (1 << k)
        ) u_stage (
            .d  (w_stage[k]),
            .en (w_shamt[k]),
            .q  (w_stage[k+1])
        );
    end

`ifdef LEFT_L_SHIFTER_REG_EN
    logic [XLEN-1:0] r_s;

    // Output register. It loads the barrel result every cycle. An
    // asynchronous reset forces S to zero and drops any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s <= '0;
        end else begin
            r_s <= w_stage[SHAMT_W];
        end
    end

    assign S = r_s;

    // B[31:5] are intentionally not used.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, B[XLEN-1:SHAMT_W]};
`else
    assign S = w_stage[SHAMT_W];

    // clk, reset and B[31:5] are intentionally not used in the
    // combinational build.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, reset, B[XLEN-1:SHAMT_W]};
`endif

endmodule

// File: tb/tb_left_l_shifter.sv
// Self-checking bench for left_l_shifter. It works with either build
// (LEFT_L_SHIFTER_REG_EN defined or not). Expected values come from a
// power-of-two multiply model and from hand-computed constants.
module tb_left_l_shifter;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    left_l_shifter dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2^(B mod 32) and keep the low 32 bits.
    function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        logic [63:0] wide;
        n    = b % 32;
        wide = {32'b0, a} * (64'd1 << n);
        return wide[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: S=%h expected %h", name, act, exp);
        end
    endtask

    // Drive the operands at a negedge, then wait until the result is valid.
    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
`ifdef LEFT_L_SHIFTER_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] prev;

        vecs[0] = '{32'hFFFF_FFFF, 32'd4,          32'hFFFF_FFF0, "ones_b4"};
        vecs[1] = '{32'hFFFF_FFFF, 32'd31,         32'h8000_0000, "ones_b31"};
        vecs[2] = '{32'h1234_5678, 32'h0000_0020,  32'h1234_5678, "b32_is_0"};
        vecs[3] = '{32'h1234_5678, 32'hFFFF_FFE1,  32'h2468_ACF0, "b_hi_ignored"};
        vecs[4] = '{32'hA5A5_A5A5, 32'd16,         32'hA5A5_0000, "a5_b16"};
        vecs[5] = '{32'hA5A5_A5A5, 32'd0,          32'hA5A5_A5A5, "a5_b0"};
        vecs[6] = '{32'h8000_0001, 32'd1,          32'h0000_0002, "msb_dropped"};
        vecs[7] = '{32'h0000_FFFF, 32'h0000_003F,  32'h8000_0000, "b63_is_31"};
        vecs[8] = '{32'h0000_0001, 32'd33,         32'h0000_0002, "b33_is_1"};
        vecs[9] = '{32'h0F0F_0F0F, 32'd8,          32'h0F0F_0F00, "0f_b8"};

        reset = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        #1;

`ifdef LEFT_L_SHIFTER_REG_EN
        // Reset state: S must be zero before any clock edge, and must stay
        // zero while reset is held.
        check("reset_init", S, 32'h0);
        A = 32'h0000_DEAD;
        B = 32'd1;
        @(posedge clk);
        #1;
        check("reset_hold", S, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        A     = 32'd3;
        B     = 32'd2;
        #1;
        check("no_load_before_edge", S, 32'h0);
        @(posedge clk);
        #1;
        check("first_load", S, 32'd12);

        // Back-to-back operands. Each result appears exactly one edge later,
        // and not before that edge.
        prev = 32'd12;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            #1;
            check($sformatf("b2b_hold_%0d", i), S, prev);
            @(posedge clk);
            #1;
            prev = ref_sll(A, B);
            check($sformatf("b2b_%0d", i), S, prev);
        end
`else
        // The combinational build has no reset state, so reset has no effect.
        A = 32'd5;
        B = 32'd3;
        #1;
        check("reset_no_effect", S, 32'd40);
        reset = 1'b0;
        #1;
        check("after_release", S, 32'd40);
`endif

        // Sweep: A=1 shifted by every amount.
        for (int i = 0; i < 32; i++) begin
            apply(32'd1, i);
            check($sformatf("sweep_b%0d", i), S, 32'd1 << i);
        end

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check(vecs[i].name, S, vecs[i].exp);
        end

        // Random operands against the model.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            apply(ra, rb);
            check($sformatf("rand_%0d", i), S, ref_sll(ra, rb));
        end

`ifdef LEFT_L_SHIFTER_REG_EN
        // Reset mid-stream: A=7, B=1 is applied, then reset arrives before
        // the edge. The value 14 must not appear while reset is held.
        @(negedge clk);
        A = 32'd7;
        B = 32'd1;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_immediate", S, 32'h0);
        @(posedge clk);
        #1;
        check("midreset_edge", S, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_release", S, 32'h0);
        @(posedge clk);
        #1;
        check("after_midreset_load", S, 32'd14);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
